// File: rtl/carry_div_pkg.sv
// Shared types and helpers for the carry_div restoring divider.
package carry_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 32'd1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_c,
  output logic             o_qbit_c
);

  logic [WIDTH:0] w_trial;

  assign w_trial  = {i_rem, i_bit};
  assign o_qbit_c = (w_trial >= {1'b0, i_divisor});
  // Trial is below 2*divisor, so the difference always fits in WIDTH bits.
  assign o_rem_c  = o_qbit_c ? WIDTH'(w_trial - {1'b0, i_divisor})
                             : w_trial[WIDTH-1:0];

endmodule

// File: rtl/carry_div.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
// Define CARRY_DIV_UNROLL2_EN to retire two restoring steps per cycle.
module carry_div
  import carry_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               err
);

  localparam int unsigned CW = cnt_width(WIDTH);
`ifdef CARRY_DIV_UNROLL2_EN
  localparam int unsigned STEPS = 2;
`else
  localparam int unsigned STEPS = 1;
`endif
  localparam logic [CW-1:0] STEP_INC = CW'(STEPS);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - STEPS);

  state_t           r_state, w_state_nxt;
  logic             r_in_ready, r_out_valid;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_div, w_div_nxt;
  logic [WIDTH-1:0] r_quot, w_quot_nxt;
  logic [WIDTH-1:0] r_remd, w_remd_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_hi, w_lo;
  logic [WIDTH-1:0] w_rem0, w_rem_step, w_shift_step;
  logic             w_q0;

  assign w_hi = dividend[2*WIDTH-1:WIDTH];
  assign w_lo = dividend[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step0 (
    .i_rem     (r_rem),
    .i_bit     (r_shift[WIDTH-1]),
    .i_divisor (r_div),
    .o_rem_c   (w_rem0),
    .o_qbit_c  (w_q0)
  );

`ifdef CARRY_DIV_UNROLL2_EN
  logic [WIDTH-1:0] w_rem1;
  logic             w_q1;

  if ((WIDTH % 2) != 0) begin : g_width_odd
    $error("carry_div: WIDTH must be even when two steps run per cycle");
  end

  div_step #(.WIDTH(WIDTH)) u_step1 (
    .i_rem     (w_rem0),
    .i_bit     (r_shift[WIDTH-2]),
    .i_divisor (r_div),
    .o_rem_c   (w_rem1),
    .o_qbit_c  (w_q1)
  );

  assign w_rem_step   = w_rem1;
  assign w_shift_step = {r_shift[WIDTH-3:0], w_q0, w_q1};
`else
  assign w_rem_step   = w_rem0;
  assign w_shift_step = {r_shift[WIDTH-2:0], w_q0};
`endif

  // Quotient bits enter the shift register from the LSB as dividend bits leave the MSB.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_rem_nxt   = r_rem;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div;
    w_quot_nxt  = r_quot;
    w_remd_nxt  = r_remd;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_div_nxt = divisor;
          if ((divisor == '0) || (w_hi >= divisor)) begin
            w_state_nxt = DONE;
            w_err_nxt   = 1'b1;
            w_quot_nxt  = '1;
            w_remd_nxt  = w_lo;
          end else begin
            w_state_nxt = BUSY;
            w_rem_nxt   = w_hi;
            w_shift_nxt = w_lo;
            w_cnt_nxt   = '0;
          end
        end
      end
      BUSY: begin
        w_rem_nxt   = w_rem_step;
        w_shift_nxt = w_shift_step;
        w_cnt_nxt   = r_cnt + STEP_INC;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b0;
          w_quot_nxt  = w_shift_step;
          w_remd_nxt  = w_rem_step;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_div       <= '0;
      r_quot      <= '0;
      r_remd      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_err       <= w_err_nxt;
      r_rem       <= w_rem_nxt;
      r_shift     <= w_shift_nxt;
      r_div       <= w_div_nxt;
      r_quot      <= w_quot_nxt;
      r_remd      <= w_remd_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign err       = r_err;

endmodule
